// File: rtl/sm_lane_mem_arbiter.sv
// sm_lane_mem_arbiter: serialises per-lane loads/stores onto one single-port synchronous memory.
// Optional LANE_READ_COALESCE_EN reuses the previous read when a load lane repeats its address.
module sm_lane_mem_arbiter #(
   parameter int N_CORES = 4,
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   input  logic              req_we,
   input  logic [N_CORES-1:0] en,
   input  logic [ADDR_W-1:0] addr [N_CORES],
   input  logic [DATA_W-1:0] data [N_CORES],
   output logic [DATA_W-1:0] q [N_CORES],
   output logic              busy,
   output logic              done,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);
   localparam int LW = (N_CORES > 1) ? $clog2(N_CORES) : 1;
   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;
   state_t state;
   logic [N_CORES-1:0] pend, src, nxt_pend;
   logic we, issue, cur_we, iss_rd, cap_rd, coal;
   logic [ADDR_W-1:0] l_addr [N_CORES];
   logic [DATA_W-1:0] l_data [N_CORES];
   logic [LW-1:0] sel, iss_lane, cap_lane;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_data, cap_data;
   // The first lane is issued on the acceptance edge straight from the core inputs.
   assign src      = (state == IDLE) ? en : pend;
   assign cur_we   = (state == IDLE) ? req_we : we;
   assign issue    = (state == IDLE) ? (req_valid && |en) : (state == ISSUE && |pend);
   assign sel_addr = (state == IDLE) ? addr[sel] : l_addr[sel];
   assign sel_data = (state == IDLE) ? data[sel] : l_data[sel];
   assign nxt_pend = src & ~(N_CORES'(1) << sel);
   always_comb begin
      sel = '0;
      for (int i = N_CORES - 1; i >= 0; i--) sel = src[i] ? LW'(i) : sel;
   end
`ifdef LANE_READ_COALESCE_EN
   logic [ADDR_W-1:0] last_addr;
   logic [DATA_W-1:0] last_rdata;
   logic last_vld, iss_coal, cap_coal;
   assign coal     = !cur_we && last_vld && sel_addr == last_addr;
   assign cap_data = cap_coal ? last_rdata : mem_rdata;
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         last_addr  <= '0;
         last_rdata <= '0;
         last_vld   <= 1'b0;
         iss_coal   <= 1'b0;
         cap_coal   <= 1'b0;
      end else begin
         iss_coal <= issue && coal;
         cap_coal <= iss_coal;
         if (issue && !cur_we && !coal) begin
            last_addr <= sel_addr;
            last_vld  <= 1'b1;
         end else if (state == FIN) last_vld <= 1'b0;
         if (cap_rd && !cap_coal) last_rdata <= mem_rdata;
      end
`else
   assign coal     = 1'b0;
   assign cap_data = mem_rdata;
`endif
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         pend      <= '0;
         we        <= 1'b0;
         iss_lane  <= '0;
         cap_lane  <= '0;
         iss_rd    <= 1'b0;
         cap_rd    <= 1'b0;
         q         <= '{default: '0};
         l_addr    <= '{default: '0};
         l_data    <= '{default: '0};
      end else begin
         mem_en   <= issue && !coal;
         mem_we   <= issue && !coal && cur_we;
         iss_rd   <= issue && !cur_we;
         cap_rd   <= iss_rd;
         cap_lane <= iss_lane;
         done     <= 1'b0;
         if (issue) begin
            mem_addr  <= sel_addr;
            mem_wdata <= sel_data;
            iss_lane  <= sel;
            pend      <= nxt_pend;
         end
         if (cap_rd) q[cap_lane] <= cap_data;
         case (state)
            IDLE: if (req_valid) begin
               we     <= req_we;
               l_addr <= addr;
               l_data <= data;
               busy   <= |en;
               done   <= ~|en;
               state  <= |en ? ISSUE : FIN;
            end
            ISSUE: if (~|pend) begin
               state <= we ? FIN : DRAIN;
               done  <= we;
               busy  <= !we;
            end
            DRAIN: begin
               state <= FIN;
               done  <= 1'b1;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_sm_lane_mem_arbiter.sv
// tb_sm_lane_mem_arbiter: scoreboard bench; a transaction-level model predicts memory accesses,
// done timing and lane results, and a negedge monitor checks them as the DUT produces them.
module tb_sm_lane_mem_arbiter;
   localparam int N = 4, AW = 16, DW = 16;
`ifdef LANE_READ_COALESCE_EN
   localparam bit COAL = 1'b1;
`else
   localparam bit COAL = 1'b0;
`endif
   typedef struct packed {int cyc; logic we; logic [AW-1:0] a; logic [DW-1:0] d;} acc_t;
   typedef struct packed {int cyc; logic [N*DW-1:0] q;} dn_t;
   logic clk, reset, req_valid, req_we, busy, done, mem_en, mem_we;
   logic [N-1:0] en;
   logic [AW-1:0] addr [N];
   logic [DW-1:0] data [N];
   logic [DW-1:0] q [N];
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;
   logic [N*DW-1:0] qv;
   logic [DW-1:0] ram [256];
   logic [DW-1:0] ref_mem [256];
   logic [N-1:0][DW-1:0] exp_q, ra, rd;
   acc_t acc_q [$];
   dn_t done_q [$];
   acc_t ma;
   dn_t md;
   int cyc = 0, ntests = 0, nfail = 0, busy_lo = 1, busy_hi = 0;

   sm_lane_mem_arbiter #(.N_CORES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we), .en(en),
      .addr(addr), .data(data), .q(q), .busy(busy), .done(done), .mem_en(mem_en),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));

   assign qv = {q[3], q[2], q[1], q[0]};

   function automatic logic [DW-1:0] init_v(input int a);
      return DW'(a * 40503) ^ 16'h5a5a;
   endfunction

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end
   always @(posedge clk) cyc <= cyc + 1;

   initial for (int i = 0; i < 256; i++) ram[i] = init_v(i);
   always @(posedge clk)
      if (mem_en) begin
         if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
         else mem_rdata <= ram[mem_addr[7:0]];
      end

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      ntests++;
      if (got !== exp) begin
         nfail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
      end
   endtask

   always @(negedge clk)
      if (reset) begin
         chk("busy", 64'(busy), 64'(cyc >= busy_lo && cyc <= busy_hi));
         if (!mem_en) chk("mem_we_without_en", 64'(mem_we), 64'(0));
         if (mem_en) begin
            if (acc_q.size() == 0) begin
               ntests++;
               nfail++;
               $display("FAIL spurious_access: got mem_en=1 addr %h expected no access (cycle %0d)", mem_addr, cyc);
            end else begin
               ma = acc_q.pop_front();
               chk("access_cycle", 64'(cyc), 64'(ma.cyc));
               chk("access_we", 64'(mem_we), 64'(ma.we));
               chk("access_addr", 64'(mem_addr), 64'(ma.a));
               if (ma.we) chk("access_wdata", 64'(mem_wdata), 64'(ma.d));
            end
         end
         if (done) begin
            if (done_q.size() == 0) begin
               ntests++;
               nfail++;
               $display("FAIL spurious_done: got done=1 expected none (cycle %0d)", cyc);
            end else begin
               md = done_q.pop_front();
               chk("done_cycle", 64'(cyc), 64'(md.cyc));
               chk("q_at_done", 64'(qv), 64'(md.q));
            end
         end
      end

   task automatic scramble();
      en = N'($urandom);
      req_we = 1'($urandom);
      for (int i = 0; i < N; i++) begin
         addr[i] = AW'($urandom);
         data[i] = DW'($urandom);
      end
   endtask

   // poke: 0 none, 1 extra request in cycle 2, 2 extra request in the done cycle, 3 reset in cycle 2
   task automatic run(input logic we_i, input logic [N-1:0] en_i, input logic [N-1:0][AW-1:0] a_i,
                      input logic [N-1:0][DW-1:0] d_i, input int poke);
      int e0, n, dc, k;
      logic [AW-1:0] la;
      logic lv, c, ab;
      e0 = cyc; n = 0; lv = 1'b0; la = '0; ab = 1'b0;
      for (int i = 0; i < N; i++)
         if (en_i[i]) begin
            n++;
            c = COAL && !we_i && lv && la == a_i[i];
            if (!c) acc_q.push_back('{e0 + n, we_i, a_i[i], d_i[i]});
            if (we_i) ref_mem[a_i[i][7:0]] = d_i[i];
            else begin
               exp_q[i] = ref_mem[a_i[i][7:0]];
               la = a_i[i];
               lv = 1'b1;
            end
         end
      dc = e0 + (n == 0 ? 1 : (we_i ? n + 1 : n + 2));
      done_q.push_back('{dc, exp_q});
      busy_lo = e0 + 1;
      busy_hi = dc - 1;
      req_valid = 1'b1;
      req_we = we_i;
      en = en_i;
      for (int i = 0; i < N; i++) begin
         addr[i] = a_i[i];
         data[i] = d_i[i];
      end
      @(negedge clk);
      req_valid = 1'b0;
      scramble();
      k = 0;
      while (!done && !ab && k < 40) begin
         if (poke == 1 && cyc == e0 + 2) begin
            scramble();
            req_valid = 1'b1;
         end
         if (poke == 3 && cyc == e0 + 2) begin
            #1 reset = 1'b0;
            acc_q.delete();
            done_q.delete();
            exp_q = '0;
            busy_lo = 1;
            busy_hi = 0;
            #1;
            chk("abort_mem_en", 64'(mem_en), 64'(0));
            chk("abort_q", 64'(qv), 64'(0));
            chk("abort_done", 64'(done), 64'(0));
            chk("abort_busy", 64'(busy), 64'(0));
            repeat (2) @(negedge clk);
            #1 reset = 1'b1;
            ab = 1'b1;
         end
         @(negedge clk);
         req_valid = 1'b0;
         k++;
      end
      if (!ab) begin
         chk("done_within_budget", 64'(done), 64'(1));
         if (poke == 2) begin
            req_valid = 1'b1;
            req_we = 1'b0;
            en = '1;
         end
         @(negedge clk);
         req_valid = 1'b0;
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got no finish expected finish by 300000");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0;
      req_valid = 1'b0;
      req_we = 1'b0;
      en = '0;
      for (int i = 0; i < N; i++) begin
         addr[i] = '0;
         data[i] = '0;
      end
      for (int i = 0; i < 256; i++) ref_mem[i] = init_v(i);
      exp_q = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      chk("rst_mem_en", 64'(mem_en), 64'(0));
      chk("rst_mem_we", 64'(mem_we), 64'(0));
      chk("rst_mem_addr", 64'(mem_addr), 64'(0));
      chk("rst_mem_wdata", 64'(mem_wdata), 64'(0));
      chk("rst_q", 64'(qv), 64'(0));
      reset = 1'b1;
      @(negedge clk);
      run(1'b1, 4'b1111, {16'd13, 16'd12, 16'd11, 16'd10}, {16'hA3, 16'hA2, 16'hA1, 16'hA0}, 0);
      run(1'b0, 4'b1111, {16'd13, 16'd12, 16'd11, 16'd10}, '0, 0);
      run(1'b1, 4'b0101, {16'd0, 16'd7, 16'd0, 16'd5}, {16'h0, 16'h2222, 16'h0, 16'h1111}, 0);
      run(1'b0, 4'b0000, {16'd1, 16'd2, 16'd3, 16'd4}, '0, 0);
      run(1'b1, 4'b0001, {16'd0, 16'd0, 16'd0, 16'd30}, {16'h0, 16'h0, 16'h0, 16'h55}, 0);
      run(1'b0, 4'b0001, {16'd0, 16'd0, 16'd0, 16'd30}, '0, 0);
      run(1'b0, 4'b1000, {16'd40, 16'd0, 16'd0, 16'd0}, '0, 0);
      run(1'b0, 4'b1111, {16'd53, 16'd52, 16'd51, 16'd50}, '0, 1);
      run(1'b0, 4'b0110, {16'd0, 16'd61, 16'd60, 16'd0}, '0, 2);
      run(1'b1, 4'b0001, {16'd0, 16'd0, 16'd0, 16'd20}, {16'h0, 16'h0, 16'h0, 16'hBEEF}, 0);
      run(1'b0, 4'b1111, {16'd20, 16'd20, 16'd20, 16'd20}, '0, 0);
      for (int t = 0; t < 40; t++) begin
         for (int i = 0; i < N; i++) begin
            ra[i] = AW'($urandom_range(0, 15));
            rd[i] = DW'($urandom);
         end
         run(1'($urandom), N'($urandom), ra, rd, 0);
      end
      run(1'b0, 4'b1111, {16'd3, 16'd2, 16'd1, 16'd0}, '0, 3);
      run(1'b0, 4'b1011, {16'd12, 16'd13, 16'd11, 16'd10}, '0, 0);
      repeat (5) @(negedge clk);
      chk("accesses_outstanding", 64'(acc_q.size()), 64'(0));
      chk("dones_outstanding", 64'(done_q.size()), 64'(0));
      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end
endmodule
